// File: rtl/norm_shift_arbiter.sv
// rtl/norm_shift_arbiter.sv - two-requester round-robin front end to one shared mantissa normalizer
//
// Purpose:
//   Two requesters compete for one leading-zero count and a 5-stage logarithmic
//   left shifter. The winner's mantissa is normalized, with the shift clamped so
//   the exponent never goes below 0. The result goes into a single output register
//   with valid/ready handshake, so throughput is one result per cycle.
//
// Optional feature:
//   NORM_STAT_EN - when defined, adds saturating per-requester grant counters
//                  o_cnt0/o_cnt1 (CNT_W bits wide).
//
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_reqN_valid / o_reqN_ready    requester N handshake (N = 0, 1)
//   i_reqN_mant / i_reqN_exp       requester N unnormalized mantissa and biased exponent
//   o_valid / i_ready              result handshake
//   o_mant, o_exp, o_zero, o_id    normalized mantissa, adjusted exponent, zero flag, source
//   o_cnt0, o_cnt1                 grant counters (NORM_STAT_EN only)

module norm_shift_arbiter #(
    parameter int EXP_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0_valid,
    input  logic             i_req1_valid,
    output logic             o_req0_ready,
    output logic             o_req1_ready,
    input  logic [27:0]      i_req0_mant,
    input  logic [27:0]      i_req1_mant,
    input  logic [EXP_W-1:0] i_req0_exp,
    input  logic [EXP_W-1:0] i_req1_exp,
`ifdef NORM_STAT_EN
    output logic [CNT_W-1:0] o_cnt0,
    output logic [CNT_W-1:0] o_cnt1,
`endif
    output logic             o_valid,
    input  logic             i_ready,
    output logic [27:0]      o_mant,
    output logic [EXP_W-1:0] o_exp,
    output logic             o_zero,
    output logic             o_id
);

    // Compare width wide enough to hold both the exponent and lzc (0..28).
    localparam int XW = (EXP_W > 6) ? EXP_W : 6;

    logic             rr_ptr;      // requester favoured on the next tie
    logic             accept;
    logic             gnt_any;
    logic             gnt_id;
    logic             xfer;
    logic [27:0]      sel_mant;
    logic [EXP_W-1:0] sel_exp;
    logic [4:0]       lzc;
    logic [4:0]       sh;
    logic [XW-1:0]    exp_x;
    logic [XW-1:0]    lzc_x;
    logic [EXP_W-1:0] nxt_exp;
    logic             nxt_zero;
    logic [27:0]      stage [0:5];

    // Arbitration: a lone requester wins outright; a tie goes to rr_ptr.
    always_comb begin
        accept       = !o_valid || i_ready;
        gnt_any      = i_req0_valid || i_req1_valid;
        gnt_id       = (i_req0_valid && i_req1_valid) ? rr_ptr : i_req1_valid;
        o_req0_ready = !i_rst && accept && i_req0_valid && !gnt_id;
        o_req1_ready = !i_rst && accept && i_req1_valid && gnt_id;
        xfer         = o_req0_ready || o_req1_ready;
        sel_mant     = gnt_id ? i_req1_mant : i_req0_mant;
        sel_exp      = gnt_id ? i_req1_exp  : i_req0_exp;
    end

    // Leading-zero count. The ascending scan lets the highest set bit win; all-zero gives 28.
    always_comb begin
        lzc = 5'd28;
        for (int i = 0; i < 28; i++) begin
            if (sel_mant[i]) begin
                lzc = 5'(27 - i);
            end
        end
    end

    // Shift selection. When exp <= lzc the shift is clamped to exp, which is
    // at most 28, so it fits in the 5-bit shift amount.
    always_comb begin
        exp_x    = XW'(sel_exp);
        lzc_x    = XW'(lzc);
        nxt_zero = (sel_mant == 28'd0);
        sh       = 5'd0;
        nxt_exp  = '0;
        if (!nxt_zero) begin
            if (exp_x > lzc_x) begin
                sh      = lzc;
                nxt_exp = sel_exp - EXP_W'(lzc);
            end else begin
                sh      = exp_x[4:0];
                nxt_exp = '0;
            end
        end
    end

    // Shared logarithmic shifter: stage k shifts by 2**k when sh[k] is set.
    always_comb begin
        stage[0] = sel_mant;
        for (int k = 0; k < 5; k++) begin
            stage[k+1] = sh[k] ? (stage[k] << (1 << k)) : stage[k];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_mant  <= '0;
            o_exp   <= '0;
            o_zero  <= 1'b0;
            o_id    <= 1'b0;
            rr_ptr  <= 1'b0;
        end else if (xfer) begin
            o_valid <= 1'b1;
            o_mant  <= stage[5];
            o_exp   <= nxt_exp;
            o_zero  <= nxt_zero;
            o_id    <= gnt_id;
            rr_ptr  <= !gnt_id;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

`ifdef NORM_STAT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_cnt0 <= '0;
            o_cnt1 <= '0;
        end else begin
            if (o_req0_ready && (o_cnt0 != '1)) begin
                o_cnt0 <= o_cnt0 + 1'b1;
            end
            if (o_req1_ready && (o_cnt1 != '1)) begin
                o_cnt1 <= o_cnt1 + 1'b1;
            end
        end
    end
`else
    // CNT_W only sizes the statistics counters, which are absent in this build.
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0) && gnt_any;
`endif

endmodule

// File: tb/tb_norm_shift_arbiter.sv
// tb/tb_norm_shift_arbiter.sv - self-checking bench for norm_shift_arbiter

module tb_norm_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic        r0, r1;
    logic [27:0] m0 = '0, m1 = '0;
    logic [7:0]  e0 = '0, e1 = '0;
    logic        ov;
    logic        rdy = 1'b0;
    logic [27:0] om;
    logic [7:0]  oe;
    logic        oz, oid;
    logic [1:0]  cnt0, cnt1;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    norm_shift_arbiter #(.EXP_W(8), .CNT_W(2)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0_valid (v0),
        .i_req1_valid (v1),
        .o_req0_ready (r0),
        .o_req1_ready (r1),
        .i_req0_mant  (m0),
        .i_req1_mant  (m1),
        .i_req0_exp   (e0),
        .i_req1_exp   (e1),
`ifdef NORM_STAT_EN
        .o_cnt0       (cnt0),
        .o_cnt1       (cnt1),
`endif
        .o_valid      (ov),
        .i_ready      (rdy),
        .o_mant       (om),
        .o_exp        (oe),
        .o_zero       (oz),
        .o_id         (oid)
    );

`ifndef NORM_STAT_EN
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference normalization: shift left until the MSB is set, counting the
    // shifts, then clamp so the exponent never drops below zero.
    task automatic ref_norm(input logic [27:0] m, input logic [7:0] e,
                            output logic [27:0] rm, output logic [7:0] re, output logic rz);
        logic [27:0] t;
        int lz;
        if (m == 0) begin
            rm = 0; re = 0; rz = 1;
        end else begin
            t = m; lz = 0;
            while (t[27] == 1'b0) begin
                t = t << 1;
                lz++;
            end
            rz = 0;
            if (int'(e) > lz) begin
                rm = t; re = 8'(int'(e) - lz);
            end else begin
                rm = m << e; re = 0;
            end
        end
    endtask

    // Reset with both requesters asserting valid: readies must stay low.
    task automatic do_reset();
        @(negedge clk);
        rst = 1; v0 = 1; v1 = 1; rdy = 1;
        m0 = 28'h0000100; e0 = 8'd100; m1 = 28'h1; e1 = 8'd5;
        #1;
        check("rst_ready0", 32'(r0), 0);
        check("rst_ready1", 32'(r1), 0);
        @(posedge clk); #1;
        check("rst_valid", 32'(ov), 0);
        @(negedge clk);
        rst = 0; v0 = 0; v1 = 0;
    endtask

    typedef struct {
        logic        id;
        logic [27:0] mant;
        logic [7:0]  exp;
        logic [27:0] emant;
        logic [7:0]  eexp;
        logic        ezero;
    } vec_t;

    vec_t tbl [12];

    logic        mvalid, mid, mptr, g, gv, acc;
    logic [27:0] mmant, rm;
    logic [7:0]  mexp, re;
    logic        mzero, rz;

    initial begin
        tbl[0]  = '{1'b0, 28'h0000100, 8'd100, 28'h8000000, 8'd81,  1'b0};
        tbl[1]  = '{1'b1, 28'h0000001, 8'd5,   28'h0000020, 8'd0,   1'b0};
        tbl[2]  = '{1'b0, 28'h0000000, 8'd77,  28'h0000000, 8'd0,   1'b1};
        tbl[3]  = '{1'b1, 28'h8000000, 8'd1,   28'h8000000, 8'd1,   1'b0};
        tbl[4]  = '{1'b0, 28'h0000001, 8'd27,  28'h8000000, 8'd0,   1'b0};
        tbl[5]  = '{1'b1, 28'h0000001, 8'd28,  28'h8000000, 8'd1,   1'b0};
        tbl[6]  = '{1'b0, 28'h0FFFFFF, 8'd4,   28'hFFFFFF0, 8'd0,   1'b0};
        tbl[7]  = '{1'b1, 28'h0FFFFFF, 8'd5,   28'hFFFFFF0, 8'd1,   1'b0};
        tbl[8]  = '{1'b0, 28'h0001234, 8'd0,   28'h0001234, 8'd0,   1'b0};
        tbl[9]  = '{1'b1, 28'h0000100, 8'd255, 28'h8000000, 8'd236, 1'b0};
        tbl[10] = '{1'b0, 28'h0000000, 8'd0,   28'h0000000, 8'd0,   1'b1};
        tbl[11] = '{1'b1, 28'h0000003, 8'd26,  28'hC000000, 8'd0,   1'b0};

        // Reset state
        do_reset();
        check("reset_mant", 32'(om), 0);
        check("reset_exp",  32'(oe), 0);
        check("reset_zero", 32'(oz), 0);
        check("reset_id",   32'(oid), 0);

        // Directed vectors, one per cycle with the consumer always ready
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rdy = 1;
            v0 = !tbl[i].id; v1 = tbl[i].id;
            m0 = tbl[i].id ? 28'hFFFFFFF : tbl[i].mant;
            e0 = tbl[i].id ? 8'hAA : tbl[i].exp;
            m1 = tbl[i].id ? tbl[i].mant : 28'hFFFFFFF;
            e1 = tbl[i].id ? tbl[i].exp : 8'hAA;
            #1;
            check($sformatf("vec%0d_ready0", i), 32'(r0), 32'(!tbl[i].id));
            check($sformatf("vec%0d_ready1", i), 32'(r1), 32'(tbl[i].id));
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid", i), 32'(ov), 1);
            check($sformatf("vec%0d_mant", i),  32'(om), 32'(tbl[i].emant));
            check($sformatf("vec%0d_exp", i),   32'(oe), 32'(tbl[i].eexp));
            check($sformatf("vec%0d_zero", i),  32'(oz), 32'(tbl[i].ezero));
            check($sformatf("vec%0d_id", i),    32'(oid), 32'(tbl[i].id));
        end
        @(negedge clk);
        v0 = 0; v1 = 0;
        @(posedge clk); #1;
        check("drain_valid", 32'(ov), 0);

        // Round robin from reset with both requesters always valid
        do_reset();
        @(negedge clk);
        v0 = 1; v1 = 1; rdy = 1;
        m0 = 28'h0000100; e0 = 8'd100; m1 = 28'h0000001; e1 = 8'd5;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("rr%0d_valid", k), 32'(ov), 1);
            check($sformatf("rr%0d_id", k), 32'(oid), 32'(k % 2));
            check($sformatf("rr%0d_mant", k), 32'(om), (k % 2) ? 32'h20 : 32'h8000000);
        end
        @(negedge clk);
        v0 = 0; v1 = 0;

        // Back-pressure: result held, readies low, then drain and grant requester 1
        do_reset();
        @(negedge clk);
        v0 = 1; v1 = 0; rdy = 1; m0 = 28'h0000100; e0 = 8'd100;
        @(posedge clk); #1;
        check("stall_load_id", 32'(oid), 0);
        @(negedge clk);
        v0 = 1; v1 = 1; rdy = 0; m1 = 28'h0000001; e1 = 8'd5;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("stall%0d_ready0", k), 32'(r0), 0);
            check($sformatf("stall%0d_ready1", k), 32'(r1), 0);
            @(posedge clk); #1;
            check($sformatf("stall%0d_valid", k), 32'(ov), 1);
            check($sformatf("stall%0d_mant", k), 32'(om), 32'h8000000);
            check($sformatf("stall%0d_exp", k), 32'(oe), 81);
            check($sformatf("stall%0d_id", k), 32'(oid), 0);
            @(negedge clk);
        end
        rdy = 1;
        #1;
        check("unstall_ready0", 32'(r0), 0);
        check("unstall_ready1", 32'(r1), 1);
        @(posedge clk); #1;
        check("unstall_id", 32'(oid), 1);
        check("unstall_mant", 32'(om), 32'h20);
        // Reset while a result is held must drop it
        @(negedge clk);
        rdy = 0;
        do_reset();

        // Randomized traffic against the reference model
        do_reset();
        mvalid = 0; mptr = 0; mid = 0; mmant = 0; mexp = 0; mzero = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            m0 = 28'($urandom()) >> $urandom_range(0, 28);
            m1 = 28'($urandom()) >> $urandom_range(0, 28);
            if ($urandom_range(0, 7) == 0) m0 = 0;
            if ($urandom_range(0, 7) == 0) m1 = 0;
            e0 = $urandom_range(0, 1) ? 8'($urandom_range(0, 32)) : 8'($urandom_range(0, 255));
            e1 = $urandom_range(0, 1) ? 8'($urandom_range(0, 32)) : 8'($urandom_range(0, 255));
            acc = !mvalid || rdy;
            gv = v0 || v1;
            g = (v0 && v1) ? mptr : v1;
            #1;
            check("rnd_ready0", 32'(r0), 32'(acc && gv && !g));
            check("rnd_ready1", 32'(r1), 32'(acc && gv && g));
            @(posedge clk);
            if (acc && gv) begin
                ref_norm(g ? m1 : m0, g ? e1 : e0, rm, re, rz);
                mvalid = 1; mmant = rm; mexp = re; mzero = rz; mid = g; mptr = !g;
            end else if (rdy) begin
                mvalid = 0;
            end
            #1;
            check("rnd_valid", 32'(ov), 32'(mvalid));
            if (mvalid) begin
                check("rnd_mant", 32'(om), 32'(mmant));
                check("rnd_exp", 32'(oe), 32'(mexp));
                check("rnd_zero", 32'(oz), 32'(mzero));
                check("rnd_id", 32'(oid), 32'(mid));
            end
        end

`ifdef NORM_STAT_EN
        // Saturating counters with CNT_W=2
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            v0 = 0; v1 = 1; rdy = 1;
            @(posedge clk);
        end
        #1;
        check("cnt1_sat", 32'(cnt1), 3);
        check("cnt0_idle", 32'(cnt0), 0);
        do_reset();
        check("cnt0_rst", 32'(cnt0), 0);
        check("cnt1_rst", 32'(cnt1), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
